mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 The block SHALL provide: reset_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL provide: start_mult  input  1  one-cycle request for a signed 32x32 multiply.
REQ-004 The block SHALL provide: start_div  input  1  one-cycle request for a signed 32/32 divide.
REQ-005 The block SHALL provide: a  input  32  multiplicand or dividend (rs).
REQ-006 The block SHALL provide: b  input  32  multiplier or divisor (rt).
REQ-007 The block SHALL provide: hi  output  32  HI register; it feeds write-data select code 0011.
REQ-008 The block SHALL provide: lo  output  32  LO register; it feeds write-data select code 0100.
REQ-009 The block SHALL provide: busy  output  1  high while an operation is in progress.
REQ-010 The block SHALL provide: done  output  1  single-cycle pulse when hi/lo hold a new result.
REQ-011 The block SHALL provide: div_zero  output  1  single-cycle pulse, concurrent with done, for a divide by zero.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, MULT, DIV, DONE.
REQ-013 Start inputs SHALL be sampled only in IDLE; starts in any other state SHALL be ignored.
REQ-014 If start_mult and start_div are both high in IDLE, multiply SHALL win and start_div SHALL be ignored.
REQ-015 At start edge N, the block SHALL capture a and b internally, clear the iteration counter to 0, and enter MULT or DIV; later changes to a and b SHALL NOT affect the result.
REQ-016 MULT SHALL implement radix-2 Booth, one iteration per clock, 32 iterations, 65-bit accumulator with arithmetic right shift.
REQ-017 DIV SHALL implement restoring division on operand magnitudes, one quotient bit per clock, 32 iterations, followed by sign correction.
REQ-018 The 32nd iteration SHALL occur at edge N+32; at that same edge hi/lo SHALL be loaded and the state SHALL go to DONE.
REQ-019 DONE SHALL last exactly one cycle (done=1), then return to IDLE at edge N+33; a new start SHALL be accepted from edge N+34 onward.
REQ-020 busy SHALL be 1 in MULT, DIV and DONE, and 0 in IDLE.
REQ-021 Multiply result: {hi,lo} SHALL equal the 64-bit two's-complement product of signed a and signed b.
REQ-022 Divide result: lo SHALL be the quotient truncated toward zero, and hi SHALL be the remainder carrying the dividend's sign.
REQ-023 Divide 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no flag raised.
REQ-024 Divide by zero (b==0 at start): the block SHALL go IDLE->DONE at edge N+1, pulse div_zero and done together, and leave hi/lo unchanged.
REQ-025 hi and lo SHALL change only at a result load or at reset; all other cycles SHALL hold them.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
REQ-027 Reset during MULT/DIV SHALL abort the operation; no partial result SHALL reach hi/lo, and no done SHALL pulse after release.
REQ-028 After reset_n returns to 1, the first rising edge SHALL be able to accept a start.

Verification
REQ-029 Multiply: start_mult, a=7, b=0xFFFFFFFD (-3) -> at edge N+32, hi=0xFFFFFFFF, lo=0xFFFFFFEB; done is high for one cycle, and busy is high for 33 cycles.
REQ-030 Multiply, extreme operands: a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 Signed divide: start_div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; a=100, b=7 -> lo=14, hi=2.
REQ-032 Divide by zero: hi/lo preloaded to 5/9; start_div, b=0 -> at edge N+1 div_zero=1 and done=1; hi=5, lo=9 remain unchanged.
REQ-033 Start while busy: start_div pulsed at iteration 5 of a multiply -> it is ignored and the multiply result is correct.
REQ-034 Reset mid-operation: reset_n pulsed low at iteration 10 -> all outputs are 0 immediately, and no done pulses in the following 40 cycles.
REQ-035 Simultaneous start: start_mult=start_div=1 with a=6, b=4 -> lo=24, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring)
// unit. The result goes to HI/LO. Each operation takes 32 iterations plus one DONE cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state, state_d;
    logic [4:0]  cnt;
    logic [64:0] acc;
    logic [31:0] m_q;
    logic        neg_q, neg_r, dz_q;

    logic        take_mult, take_div, last;
    logic [32:0] booth_sum, diff;
    logic [64:0] mult_next, div_next;
    logic [31:0] q_res, r_res;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d   = state;
        busy      = 1'b1;
        done      = 1'b0;
        div_zero  = 1'b0;
        take_mult = 1'b0;
        take_div  = 1'b0;
        last      = (cnt == 5'd31);
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_mult) begin
                    take_mult = 1'b1;
                    state_d   = MULT;
                end else if (start_div) begin
                    take_div = 1'b1;
                    state_d  = DIV;
                end
            end
            MULT: if (last) state_d = DONE;
            DIV:  if (dz_q || last) state_d = DONE;
            DONE: begin
                done     = 1'b1;
                div_zero = dz_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Booth step: the add is 33 bits wide, so A - M cannot overflow when M = -2^31.
    // The 33-bit sum is shifted straight into the accumulator.
    always_comb begin
        booth_sum = {acc[64], acc[64:33]};
        unique case (acc[1:0])
            2'b01:   booth_sum = {acc[64], acc[64:33]} + {m_q[31], m_q};
            2'b10:   booth_sum = {acc[64], acc[64:33]} - {m_q[31], m_q};
            default: booth_sum = {acc[64], acc[64:33]};
        endcase
        mult_next = {booth_sum, acc[32:1]};
    end

    // Restoring step: acc[63:32] holds the partial remainder and acc[31:0] holds the quotient.
    always_comb begin
        diff = acc[63:31] - {1'b0, m_q};
        if (!diff[32]) div_next = {1'b0, diff[31:0], acc[30:0], 1'b1};
        else           div_next = {1'b0, acc[62:31], acc[30:0], 1'b0};
        q_res = neg_q ? (32'd0 - div_next[31:0])  : div_next[31:0];
        r_res = neg_r ? (32'd0 - div_next[63:32]) : div_next[63:32];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            acc   <= '0;
            m_q   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz_q  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (take_mult) begin
                cnt  <= '0;
                m_q  <= a;
                acc  <= {32'd0, b, 1'b0};
                dz_q <= 1'b0;
            end else if (take_div) begin
                cnt   <= '0;
                m_q   <= b[31] ? (32'd0 - b) : b;
                acc   <= {33'd0, (a[31] ? (32'd0 - a) : a)};
                neg_q <= a[31] ^ b[31];
                neg_r <= a[31];
                dz_q  <= (b == '0);
            end else if (state == MULT) begin
                cnt <= cnt + 5'd1;
                acc <= mult_next;
                if (last) begin
                    hi <= mult_next[64:33];
                    lo <= mult_next[32:1];
                end
            end else if (state == DIV && !dz_q) begin
                cnt <= cnt + 5'd1;
                acc <= div_next;
                if (last) begin
                    hi <= r_res;
                    lo <= q_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit. It checks results, latency, busy length,
// start arbitration, divide-by-zero, and asynchronous reset behaviour.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_mult, start_div;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int vectors     = 0;
    int miscompares = 0;

    mult_div_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_mult(start_mult),
        .start_div (start_div),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sm, input logic sd, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start_mult = sm;
        start_div  = sd;
        a          = av;
        b          = bv;
    endtask

    // Consumes start edge N, then watches up to 40 more edges.
    // A start_div pulse is injected after edge `inj` (0 means no injection).
    task automatic finish(input int inj, output int lat, output int bcnt,
                          output logic dzs, output int chg);
        logic [31:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = $urandom;
        b          = $urandom;
        lat  = -1;
        bcnt = busy ? 1 : 0;
        dzs  = 1'b0;
        chg  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start_div = (k == inj);
            if (busy) bcnt++;
            if (done && lat < 0) begin
                lat = k;
                dzs = div_zero;
            end
            if (lat < 0 && (hi !== hi0 || lo !== lo0)) chg++;
            if (!busy) break;
        end
        start_div = 1'b0;
    endtask

    int   lat, bcnt, chg, dcnt;
    logic dzs;

    initial begin
        reset_n    = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a          = '0;
        b          = '0;
        #2 reset_n = 1'b0;
        #2;
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_flags", {busy, done, div_zero}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 7 * -3
        launch(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
        finish(0, lat, bcnt, dzs, chg);
        check("mul_lat", lat, 32);
        check("mul_busy_len", bcnt, 33);
        check("mul_hi", hi, 32'hFFFFFFFF);
        check("mul_lo", lo, 32'hFFFFFFEB);
        check("mul_done_pulse", done, 0);
        check("mul_hold", chg, 0);

        // Extreme operands; start accepted at edge N+34.
        launch(1'b1, 1'b0, 32'h80000000, 32'h80000000);
        finish(0, lat, bcnt, dzs, chg);
        check("mulx_lat", lat, 32);
        check("mulx_res", {hi, lo}, 64'h40000000_00000000);

        launch(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2);
        finish(0, lat, bcnt, dzs, chg);
        check("div_neg_lat", lat, 32);
        check("div_neg_res", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("div_neg_dz", dzs, 0);

        launch(1'b0, 1'b1, 32'd100, 32'd7);
        finish(0, lat, bcnt, dzs, chg);
        check("div_pos_res", {hi, lo}, {32'd2, 32'd14});
        check("div_pos_busy_len", bcnt, 33);

        launch(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        finish(0, lat, bcnt, dzs, chg);
        check("div_ovf_res", {hi, lo}, {32'h00000000, 32'h80000000});
        check("div_ovf_dz", dzs, 0);

        // Preload hi=5 and lo=9 via 95/10, then divide by zero.
        launch(1'b0, 1'b1, 32'd95, 32'd10);
        finish(0, lat, bcnt, dzs, chg);
        check("preload", {hi, lo}, {32'd5, 32'd9});
        launch(1'b0, 1'b1, 32'd123, 32'd0);
        finish(0, lat, bcnt, dzs, chg);
        check("dz_lat", lat, 1);
        check("dz_flag", dzs, 1);
        check("dz_busy_len", bcnt, 2);
        check("dz_hold", {hi, lo}, {32'd5, 32'd9});
        check("dz_flag_clear", div_zero, 0);

        // start_div during iteration 5 of 1234 * -5678 = -7006652
        launch(1'b1, 1'b0, 32'd1234, 32'hFFFFE9D2);
        finish(5, lat, bcnt, dzs, chg);
        check("busy_start_lat", lat, 32);
        check("busy_start_res", {hi, lo}, 64'hFFFFFFFF_FF951644);
        check("busy_start_idle", busy, 0);

        launch(1'b1, 1'b1, 32'd6, 32'd4);
        finish(0, lat, bcnt, dzs, chg);
        check("simul_res", {hi, lo}, {32'd0, 32'd24});

        // Reset pulsed at iteration 10 of a multiply.
        launch(1'b1, 1'b0, 32'd1000, 32'd1000);
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_hilo", {hi, lo}, 0);
        check("rst_mid_flags", {busy, done, div_zero}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dcnt++;
        end
        check("rst_no_done", dcnt, 0);
        check("rst_hilo_stay", {hi, lo}, 0);

        // A start on the first edge after reset release.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n    = 1'b1;
        start_mult = 1'b1;
        a          = 32'd3;
        b          = 32'd5;
        finish(0, lat, bcnt, dzs, chg);
        check("post_rst_lat", lat, 32);
        check("post_rst_res", {hi, lo}, {32'd0, 32'd15});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
